// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, bit-timing FSM and a FWFT byte FIFO
// with sticky framing-error and overrun flags.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DEPTH        = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       uartRxPin,
   input  logic       rdEn,
   input  logic       errClr,
   output logic [7:0] rxData,
   output logic       rxValid,
   output logic       frameErr,
   output logic       overrun
);

   localparam int H  = (CLKS_PER_BIT - 1) / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] C_BIT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_HALF = CW'(H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   logic            r_sync1, r_sync2;
   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [2:0]      r_bit_idx, w_bit_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic            w_rxs, w_cnt_zero, w_push, w_frame_set;

   logic [7:0]      r_mem [DEPTH];
   logic [AW:0]     r_wr_ptr, r_rd_ptr;
   logic            w_empty, w_full, w_pop, w_wr, w_ovr_set;
   logic            r_frame_err, r_overrun;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= uartRxPin;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs      = r_sync2;
   assign w_cnt_zero = (r_cnt == '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
      end
   end

   // Counter counts down to zero; the sample is taken in the cycle it reads zero.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit_idx;
      w_shift_nxt = r_shift;
      w_push      = 1'b0;
      w_frame_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_rxs) begin
               w_cnt_nxt   = C_HALF;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (!w_rxs) begin
               w_cnt_nxt   = C_BIT;
               w_bit_nxt   = '0;
               w_state_nxt = S_DATA;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DATA: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_shift_nxt = {w_rxs, r_shift[7:1]};
               w_cnt_nxt   = C_BIT;
               if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
               else                   w_bit_nxt   = r_bit_idx + 3'd1;
            end
         end
         S_STOP: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (w_rxs) begin
               w_push      = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_frame_set = 1'b1;
               w_state_nxt = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (w_rxs) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Read side: rxData/rxValid present the head; rdEn with rxValid=1 pops at the edge.
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop     = rdEn && !w_empty;
   assign w_wr      = w_push && (!w_full || w_pop);
   assign w_ovr_set = w_push && w_full && !w_pop;

   always_ff @(posedge CLK) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_frame_set)  r_frame_err <= 1'b1;
         else if (errClr)  r_frame_err <= 1'b0;
         if (w_ovr_set)    r_overrun   <= 1'b1;
         else if (errClr)  r_overrun   <= 1'b0;
      end
   end

   assign rxValid  = !w_empty;
   assign rxData   = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
   assign frameErr = r_frame_err;
   assign overrun  = r_overrun;

endmodule
